// File: rtl/shift_out_ctrl.sv
// Parallel-to-serial driver for a 595-style shift/storage register chain.
// Optional build macro: SHIFT_OUT_LSB_FIRST_EN (LSB-first bit order).
module shift_out_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CLKDIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             serdata,
    output logic             serclk,
    output logic             latch,
    output logic [4:0]       count
);

    localparam int unsigned PRESC_W = 8;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               serdata_q, serdata_d;
    logic               serclk_q, serclk_d;
    logic               latch_q, latch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               phase_end_c;
    logic               last_bit_c;
    logic [WIDTH-1:0]   shifted_c;
    logic               first_bit_c;
    logic               next_bit_c;

    assign phase_end_c = (presc_q == PRESC_W'(CLKDIV - 1));
    assign last_bit_c  = (count_q == CNT_W'(WIDTH));

    // Bit-order selection: which end leaves first and which way the register moves.
`ifdef SHIFT_OUT_LSB_FIRST_EN
    assign shifted_c   = shreg_q >> 1;
    assign first_bit_c = data[0];
    assign next_bit_c  = shifted_c[0];
`else
    assign shifted_c   = shreg_q << 1;
    assign first_bit_c = data[WIDTH-1];
    assign next_bit_c  = shifted_c[WIDTH-1];
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            shreg_q   <= '0;
            count_q   <= '0;
            serdata_q <= 1'b0;
            serclk_q  <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            shreg_q   <= shreg_d;
            count_q   <= count_d;
            serdata_q <= serdata_d;
            serclk_q  <= serclk_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and phase prescaler.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                presc_d = phase_end_c ? '0 : presc_q + PRESC_W'(1);
                if (phase_end_c) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                presc_d = phase_end_c ? '0 : presc_q + PRESC_W'(1);
                if (phase_end_c) begin
                    state_d = last_bit_c ? ST_LATCH : ST_LO;
                end
            end
            ST_LATCH: begin
                presc_d = phase_end_c ? '0 : presc_q + PRESC_W'(1);
                if (phase_end_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; serdata only moves with serclk falling.
    always_comb begin
        shreg_d   = shreg_q;
        count_d   = count_q;
        serdata_d = serdata_q;
        serclk_d  = serclk_q;
        latch_d   = latch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = data;
                    serdata_d = first_bit_c;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    serclk_d  = 1'b0;
                    latch_d   = 1'b0;
                end
            end
            ST_LO: begin
                if (phase_end_c) begin
                    serclk_d = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (phase_end_c) begin
                    serclk_d = 1'b0;
                    if (last_bit_c) begin
                        latch_d = 1'b1;
                    end else begin
                        shreg_d   = shifted_c;
                        serdata_d = next_bit_c;
                    end
                end
            end
            ST_LATCH: begin
                if (phase_end_c) begin
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign serdata = serdata_q;
    assign serclk  = serclk_q;
    assign latch   = latch_q;
    assign count   = count_q;

endmodule

// File: tb/tb_shift_out_ctrl.sv
// Directed bench for shift_out_ctrl: three instances (16/1, 16/3, 1/1) sharing clk and reset.
module tb_shift_out_ctrl;

    logic        clk;
    logic        reset;
    logic        start_r [3];
    logic [15:0] data_r  [3];
    logic [0:0]  data_w1;
    logic        busy_w    [3];
    logic        done_w    [3];
    logic        serdata_w [3];
    logic        serclk_w  [3];
    logic        latch_w   [3];
    logic [4:0]  count_w   [3];

    int n_cmp = 0;
    int n_bad = 0;

    assign data_w1 = data_r[2][0:0];

    shift_out_ctrl #(.WIDTH(16), .CLKDIV(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_r[0]), .data(data_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .serdata(serdata_w[0]),
        .serclk(serclk_w[0]), .latch(latch_w[0]), .count(count_w[0])
    );

    shift_out_ctrl #(.WIDTH(16), .CLKDIV(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_r[1]), .data(data_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .serdata(serdata_w[1]),
        .serclk(serclk_w[1]), .latch(latch_w[1]), .count(count_w[1])
    );

    shift_out_ctrl #(.WIDTH(1), .CLKDIV(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_r[2]), .data(data_w1),
        .busy(busy_w[2]), .done(done_w[2]), .serdata(serdata_w[2]),
        .serclk(serclk_w[2]), .latch(latch_w[2]), .count(count_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: busy, done, serclk, latch, serdata, count[4:0].
    function automatic logic [9:0] obs(input int id);
        return {busy_w[id], done_w[id], serclk_w[id], latch_w[id], serdata_w[id], count_w[id]};
    endfunction

    function automatic logic bit_of(input logic [15:0] word, input int w, input int k);
`ifdef SHIFT_OUT_LSB_FIRST_EN
        return word[k];
`else
        return word[w-1-k];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer on instance id; edge 0 is the accepting edge. hold keeps start high
    // (data is scrambled while busy); abort_at stops after that edge without releasing start.
    task automatic xfer(input int id, input int w, input int div, input logic [15:0] word,
                        input bit hold, input int abort_at);
        int          fin;
        int          last;
        int          p;
        int          k;
        logic [9:0]  exp;
        fin  = (2*w + 1) * div;
        last = fin + (hold ? 0 : 1);
        data_r[id]  = word;
        start_r[id] = 1'b1;
        for (int e = 0; e <= last; e++) begin
            @(posedge clk);
            #1;
            p = e / div;
            k = (p < 2*w) ? p / 2 : w - 1;
            exp = {1'(e < fin), 1'(e == fin), 1'((p < 2*w) && (p % 2 == 1)),
                   1'(p == 2*w), bit_of(word, w, k),
                   5'((p < 2*w) ? (p + 1) / 2 : w)};
            check($sformatf("dut%0d_w%0d_e%0d", id, word, e), 32'(obs(id)), 32'(exp));
            if (e == 0) begin
                if (!hold) start_r[id] = 1'b0;
                data_r[id] = ~word;
            end
            if (e == abort_at) return;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            data_r[i]  = 16'h0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("reset_dut%0d", i), 32'(obs(i)), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 32'(obs(0)), 32'h0);

        xfer(0, 16, 1, 16'hA5C3, 1'b0, -1);
        xfer(1, 16, 3, 16'h0001, 1'b0, -1);
        xfer(2, 1, 1, 16'h0001, 1'b0, -1);
        xfer(0, 16, 1, 16'h8001, 1'b0, -1);

        // Back-to-back with start held; data scrambled while busy.
        xfer(0, 16, 1, 16'h1234, 1'b1, -1);
        xfer(0, 16, 1, 16'hF00F, 1'b1, -1);
        xfer(0, 16, 1, 16'h6BD2, 1'b0, -1);

        // Abort at edge 10: outputs clear asynchronously, no latch and no done follow.
        xfer(0, 16, 1, 16'hFFFF, 1'b1, 10);
        start_r[0] = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_clear", 32'(obs(0)), 32'h0);
        @(posedge clk);
        #1;
        check("reset_held", 32'(obs(0)), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("no_latch_done_%0d", i), 32'(obs(0)), 32'h0);
        end
        xfer(0, 16, 1, 16'h5A3C, 1'b0, -1);
        xfer(2, 1, 1, 16'h0000, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
